// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : hazard_tracker
// Purpose : D-stage stall/forward decisions from a shadow E/M/W pipeline,
//           plus a multiply/divide busy counter guarding HI/LO readers.
// Revision: 1.0
// ============================================================================
module hazard_tracker #(
    parameter int STAGES  = 3,
    parameter int TW      = 3,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          d_valid,
    input  logic                          d_need_rs,
    input  logic                          d_need_rt,
    input  logic [4:0]                    d_rs,
    input  logic [4:0]                    d_rt,
    input  logic [TW-1:0]                 d_tuse_rs,
    input  logic [TW-1:0]                 d_tuse_rt,
    input  logic [4:0]                    d_dst,
    input  logic [TW-1:0]                 d_tnew,
    input  logic                          d_md_start,
    input  logic                          d_md_div,
    input  logic                          d_uses_hilo,
    output logic                          stall,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rs_sel,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rt_sel,
    output logic                          md_busy
);

    localparam int SW = $clog2(STAGES+1);
    localparam int MW = $clog2(DIV_CYC+1);
    localparam logic [MW-1:0] C_MUL_LD = MW'(MUL_CYC);
    localparam logic [MW-1:0] C_DIV_LD = MW'(DIV_CYC);

    logic [STAGES-1:0]         valid_q, valid_d;
    logic [STAGES-1:0][4:0]    dst_q,   dst_d;
    logic [STAGES-1:0][TW-1:0] tnew_q,  tnew_d;
    logic [MW-1:0]             md_cnt_q, md_cnt_d;

    logic          rs_hit, rt_hit;
    logic [TW-1:0] rs_tnew, rt_tnew;
    logic [SW-1:0] rs_idx, rt_idx;
    logic          rs_stall, rt_stall, hilo_stall;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_idx  = '0;
        rt_idx  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_q[k] && (dst_q[k] != 5'd0) && (dst_q[k] == d_rs)) begin
                rs_hit  = 1'b1;
                rs_tnew = tnew_q[k];
                rs_idx  = SW'(k + 1);
            end
            if (valid_q[k] && (dst_q[k] != 5'd0) && (dst_q[k] == d_rt)) begin
                rt_hit  = 1'b1;
                rt_tnew = tnew_q[k];
                rt_idx  = SW'(k + 1);
            end
        end
    end

    always_comb begin
        md_busy    = (md_cnt_q != '0);
        rs_stall   = d_valid && d_need_rs && (d_rs != 5'd0) && rs_hit && (rs_tnew > d_tuse_rs);
        rt_stall   = d_valid && d_need_rt && (d_rt != 5'd0) && rt_hit && (rt_tnew > d_tuse_rt);
        hilo_stall = d_valid && d_uses_hilo && md_busy;
        stall      = rs_stall || rt_stall || hilo_stall;

        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if (d_need_rs && (d_rs != 5'd0) && rs_hit && (rs_tnew == '0))
            fwd_rs_sel = rs_idx;
        if (d_need_rt && (d_rt != 5'd0) && rt_hit && (rt_tnew == '0))
            fwd_rt_sel = rt_idx;
    end

    always_comb begin
        valid_d = '0;
        dst_d   = '0;
        tnew_d  = '0;
        if (d_valid && !stall) begin
            valid_d[0] = 1'b1;
            dst_d[0]   = d_dst;
            tnew_d[0]  = d_tnew;
        end
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            dst_d[k]   = dst_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
        end

        md_cnt_d = md_cnt_q;
        if (d_valid && d_md_start && !stall)
            md_cnt_d = d_md_div ? C_DIV_LD : C_MUL_LD;
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            dst_q    <= '0;
            tnew_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            dst_q    <= dst_d;
            tnew_q   <= tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// Testbench for hazard_tracker: one-cycle directed vectors, then multi-cycle
// multiply/divide and asynchronous reset sequences.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid, d_need_rs, d_need_rt;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_uses_hilo;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_tracker #(.STAGES(3), .TW(3), .MUL_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_valid    (d_valid),
        .d_need_rs  (d_need_rs),
        .d_need_rt  (d_need_rt),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_uses_hilo(d_uses_hilo),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    typedef struct {
        logic       v, nrs, nrt;
        logic [4:0] rs, rt;
        logic [2:0] urs, urt;
        logic [4:0] dst;
        logic [2:0] tnew;
        logic       hilo;
        logic       e_stall;
        logic [1:0] e_rs, e_rt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic v, input logic nrs, input logic nrt,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [2:0] urs, input logic [2:0] urt,
                                input logic [4:0] dst, input logic [2:0] tnew,
                                input logic hilo, input logic es,
                                input logic [1:0] ers, input logic [1:0] ert);
        vec_t r;
        r.v = v; r.nrs = nrs; r.nrt = nrt; r.rs = rs; r.rt = rt;
        r.urs = urs; r.urt = urt; r.dst = dst; r.tnew = tnew; r.hilo = hilo;
        r.e_stall = es; r.e_rs = ers; r.e_rt = ert;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic [1:0] ers,
                             input logic [1:0] ert, input logic eb);
        check({tag, " stall"},      int'(stall),      int'(es));
        check({tag, " fwd_rs_sel"}, int'(fwd_rs_sel), int'(ers));
        check({tag, " fwd_rt_sel"}, int'(fwd_rt_sel), int'(ert));
        check({tag, " md_busy"},    int'(md_busy),    int'(eb));
    endtask

    task automatic idle();
        d_valid = 0; d_need_rs = 0; d_need_rt = 0; d_rs = 0; d_rt = 0;
        d_tuse_rs = 0; d_tuse_rt = 0; d_dst = 0; d_tnew = 0;
        d_md_start = 0; d_md_div = 0; d_uses_hilo = 0;
    endtask

    // Inputs change just after the rising edge; outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Pipeline contents after each vector's clock are noted as {dst,tnew}.
        vecs[0]  = mk(1,0,0, 0,0, 0,0, 1,2, 0, 0,0,0); // lw $1 -> E{1,2}
        vecs[1]  = mk(1,1,0, 1,0, 1,0, 4,0, 0, 1,0,0); // add reads $1 too early
        vecs[2]  = mk(1,1,0, 1,0, 1,0, 4,0, 0, 0,0,0); // M{1,1}: released
        vecs[3]  = mk(1,0,0, 0,0, 0,0, 2,1, 0, 0,0,0); // addu $2 -> E{2,1}, M{4,0}
        vecs[4]  = mk(1,1,1, 2,4, 0,0, 0,0, 0, 1,0,2); // beq $2 stalls; $4 from M
        vecs[5]  = mk(1,1,1, 2,4, 0,0, 0,0, 0, 0,2,3); // $2 from M, $4 from W
        vecs[6]  = mk(1,1,0, 2,0, 0,0, 0,2, 0, 0,3,0); // lw $0; $2 from W
        vecs[7]  = mk(1,1,1, 0,0, 1,1, 3,0, 0, 0,0,0); // reads $0: never stall/forward
        vecs[8]  = mk(1,1,0, 3,3, 0,0, 3,0, 0, 0,1,0); // $3 from E; rt not needed
        vecs[9]  = mk(1,1,1, 3,3, 0,0, 0,0, 0, 0,1,1); // two $3 writers: youngest wins
        vecs[10] = mk(1,1,1, 3,5, 0,0, 0,0, 0, 0,2,0); // $3 at M and W -> M
        vecs[11] = mk(0,0,0, 0,0, 0,0, 0,0, 0, 0,0,0); // idle
        vecs[12] = mk(1,0,0, 0,0, 0,0, 6,2, 0, 0,0,0); // writer $6 tnew=2
        vecs[13] = mk(1,1,0, 6,0, 1,0, 0,0, 0, 1,0,0); // 2 > 1: stall
        vecs[14] = mk(1,1,0, 6,0, 1,0, 0,0, 0, 0,0,0); // 1 > 1 false, not ready
        vecs[15] = mk(1,1,0, 6,0, 0,0, 0,0, 1, 0,3,0); // W tnew saturated at 0
        vecs[16] = mk(1,0,0, 0,0, 0,0, 7,1, 0, 0,0,0); // writer $7 tnew=1
        vecs[17] = mk(1,0,1, 0,7, 0,0, 0,0, 0, 1,0,0); // rt-side stall
        vecs[18] = mk(1,0,1, 0,7, 0,0, 0,0, 0, 0,0,2); // rt forwarded from M

        idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0);
        reset_n = 1;

        for (int i = 0; i < 19; i++) begin
            next_cycle();
            d_valid = vecs[i].v; d_need_rs = vecs[i].nrs; d_need_rt = vecs[i].nrt;
            d_rs = vecs[i].rs; d_rt = vecs[i].rt;
            d_tuse_rs = vecs[i].urs; d_tuse_rt = vecs[i].urt;
            d_dst = vecs[i].dst; d_tnew = vecs[i].tnew;
            d_md_start = 0; d_md_div = 0; d_uses_hilo = vecs[i].hilo;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_rs, vecs[i].e_rt, 1'b0);
        end

        // mult accepted, mfhi held for 5 busy cycles
        next_cycle(); idle();
        next_cycle(); idle();
        d_valid = 1; d_md_start = 1; d_md_div = 0; d_uses_hilo = 1;
        @(negedge clk);
        check_all("mult start", 0, 0, 0, 0);
        next_cycle(); idle();
        d_valid = 1; d_uses_hilo = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_all($sformatf("mult busy%0d", i), 1, 0, 0, 1);
            next_cycle();
        end
        // Release cycle: a divide starts right as the multiply finishes.
        d_md_start = 1; d_md_div = 1;
        @(negedge clk);
        check_all("div start on release", 0, 0, 0, 0);
        next_cycle();
        d_md_start = 0; d_md_div = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all($sformatf("div busy%0d", i), 1, 0, 0, 1);
            next_cycle();
        end
        @(negedge clk);
        check_all("div released", 0, 0, 0, 0);

        // Divide interrupted by reset with 6 cycles remaining
        next_cycle(); idle();
        d_valid = 1; d_md_start = 1; d_md_div = 1;
        @(negedge clk);
        check_all("div2 start", 0, 0, 0, 0);
        next_cycle(); idle();
        d_valid = 1; d_uses_hilo = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all($sformatf("div2 busy%0d", i), 1, 0, 0, 1);
            next_cycle();
        end
        idle();
        d_valid = 1; d_dst = 9; d_tnew = 2;
        @(negedge clk);
        check_all("div2 lw $9", 0, 0, 0, 1);
        next_cycle(); idle();
        d_valid = 1; d_uses_hilo = 1; d_need_rs = 1; d_rs = 9; d_tuse_rs = 0;
        @(negedge clk);
        check_all("pre-reset", 1, 0, 0, 1);
        #1 reset_n = 0;
        #1;
        check_all("in reset", 0, 0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check_all("post-reset", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL provide parameter STAGES, default 3, meaning number of tracked in-flight stages after D (E, M, W).
REQ-002 SHALL provide parameter TW, default 3, meaning width of Tuse/Tnew fields.
REQ-003 SHALL provide parameter MUL_CYC, default 5, meaning multiply busy cycles.
REQ-004 SHALL provide parameter DIV_CYC, default 10, meaning divide busy cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL provide the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_valid  in  1  D-stage instruction valid.
- d_need_rs, d_need_rt  in  1 each  operand read.
- d_rs, d_rt  in  5 each  source register numbers.
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until operand needed.
- d_dst  in  5  destination register (0 = none).
- d_tnew  in  TW  cycles until result available, measured from E entry.
- d_md_start  in  1  D instruction is mult/multu/div/divu/madd.
- d_md_div  in  1  1 = divide class, 0 = multiply class.
- d_uses_hilo  in  1  D instruction reads/writes HI/LO (mfhi, mflo, mthi, mtlo, md ops).
- stall  out  1  hold PC/D, inject bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  $clog2(STAGES+1) each  0 = register file, k = tracked stage k-1.
- md_busy  out  1  multiply/divide unit busy.

Function
REQ-007 SHALL hold a shadow pipeline of STAGES entries {valid, dst[4:0], tnew[TW-1:0]}; entry 0 = E.
REQ-008 SHALL shift entries k -> k+1 every clock; oldest entry discarded.
REQ-009 SHALL decrement tnew by 1 on each shift, saturating at 0.
REQ-010 SHALL load entry 0 on each clock as follows:
- stall=1 or d_valid=0: bubble {0,0,0}.
- otherwise: {1, d_dst, d_tnew}.
REQ-011 SHALL define a match for rs as an entry with valid=1, dst!=0 and dst==d_rs; the youngest (lowest-index) match alone decides; rt is handled identically.
REQ-012 SHALL assert the rs stall term iff d_valid & d_need_rs & d_rs!=0 & a youngest match exists & its tnew > d_tuse_rs; the rt term is identical.
REQ-013 SHALL set fwd_*_sel = k+1 when the youngest match is entry k with tnew==0; otherwise 0.
REQ-014 SHALL force fwd_*_sel to 0 when the register number is 0 or need_* is 0.
REQ-015 SHALL keep md counter md_cnt, width $clog2(DIV_CYC+1):
- On a clock with d_valid & d_md_start & !stall, load MUL_CYC or DIV_CYC per d_md_div.
- Otherwise decrement when non-zero.
- md_busy = (md_cnt != 0).
REQ-016 SHALL assert the HI/LO stall term iff d_valid & d_uses_hilo & md_busy.
REQ-017 SHALL output stall as the OR of the rs, rt and HI/LO terms; stall, fwd_*_sel and md_busy are combinational from current state and D inputs, i.e. 0-cycle latency.
REQ-018 SHALL let a new md start load the counter even while md_busy=0 in the same cycle the previous op finishes; an md start while busy is already stalled per REQ-016.
REQ-019 SHALL treat TW overflow as impossible: inputs satisfy d_tnew <= STAGES-1.

Reset
REQ-020 SHALL, on reset_n=0 and asynchronously, clear all entries to {0,0,0} and md_cnt to 0; stall=0, fwd_*_sel=0 and md_busy=0 whenever D inputs are idle.
REQ-021 SHALL, on reset assertion mid-stall or mid-md operation, abort immediately with no residual stall after release.

Verification
REQ-022 SHALL cover lw $1 (tnew=2) then add rs=$1 (tuse=1) -> stall=1 exactly 1 cycle; next cycle stall=0, entry1 tnew=1.
REQ-023 SHALL cover addu $2 (tnew=1) then beq rs=$2 (tuse=0) -> stall 1 cycle, then fwd_rs_sel=2 with stall=0.
REQ-024 SHALL cover lw $0 then add rs=$0 -> stall=0, fwd_rs_sel=0.
REQ-025 SHALL cover the youngest-wins rule: two writers to $3 at entries 0 (tnew=0) and 1 (tnew=0) -> fwd_rs_sel=1.
REQ-026 SHALL cover mult accepted, then mfhi held in D -> md_busy and stall high 5 cycles, then released; div gives 10 cycles.
REQ-027 SHALL cover reset_n pulsed low during a div with 6 cycles remaining -> md_busy=0 immediately, all entries invalid.
